// File: rtl/card_game_pkg.sv
// card_game_pkg
//   Constants and types shared by the memory-game blocks: the deck
//   shuffler, compareCards and the VGA board renderer.
//   - NUM_CARDS / CARD_W / IDX_W : board geometry (6x6 board, 18 pairs)
//   - LFSR_W / LFSR_SEED / LFSR_TAPS : shuffle random source
//   - card_t : one card value, slot_t : one board slot index
//   - shuf_state_t : shuffler controller states
package card_game_pkg;

  localparam int NUM_CARDS = 36;
  localparam int CARD_W    = 5;
  localparam int IDX_W     = 6;
  localparam int LFSR_W    = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [CARD_W-1:0] card_t;
  typedef logic [IDX_W-1:0]  slot_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    SHUFFLE = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4
  } shuf_state_t;

endpackage

// File: rtl/card_lfsr.sv
// card_lfsr
//   Free-running Galois LFSR (right-shifting). Advances on every clock
//   edge that is not a reset edge; loads SEED on reset.
//   Ports:
//     clock  in   system clock
//     reset  in   synchronous, active-high
//     q      out  current LFSR state (LFSR_W bits)
module card_lfsr #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
  input  logic              clock,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= SEED;
    end else begin
      // The bit shifted out feeds back into every tap position.
      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/card_deck_shuffler.sv
// card_deck_shuffler
//   Builds a shuffled memory-game deck (NUM_CARDS/2 pairs) with a
//   Fisher-Yates shuffle fed by a free-running LFSR, then streams it into
//   the card RAM one slot per cycle.
//   Ports:
//     clock      in   system clock
//     reset      in   synchronous, active-high
//     start      in   request a new shuffle (accepted in IDLE or DONE)
//     busy       out  high from FILL through the last WRITE cycle
//     done       out  high in DONE until the next accepted start or reset
//     wr_en      out  card RAM write strobe
//     wr_addr    out  card RAM slot index
//     wr_data    out  card value for wr_addr
//     dbg_state  out  controller state, for checkers
//     dbg_lfsr   out  LFSR state, for checkers
//   Handshake: start is a level sampled on every posedge while the
//   controller is in IDLE or DONE; there is no ready/ack, the rise of busy
//   on the following cycle shows the request was taken. The RAM side is a
//   write-only strobe with no back-pressure: every cycle with wr_en=1
//   carries one valid (wr_addr, wr_data) pair.
module card_deck_shuffler #(
  parameter int                NUM_CARDS = card_game_pkg::NUM_CARDS,
  parameter int                CARD_W    = card_game_pkg::CARD_W,
  parameter int                IDX_W     = card_game_pkg::IDX_W,
  parameter int                LFSR_W    = card_game_pkg::LFSR_W,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       wr_en,
  output logic [IDX_W-1:0]           wr_addr,
  output logic [CARD_W-1:0]          wr_data,
  output card_game_pkg::shuf_state_t dbg_state,
  output logic [LFSR_W-1:0]          dbg_lfsr
);

  import card_game_pkg::*;

  localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(LFSR_TAPS);
  localparam logic [IDX_W-1:0]  LAST_SLOT = IDX_W'(NUM_CARDS - 1);

  logic [LFSR_W-1:0] lfsr_q;
  shuf_state_t       state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  mask;
  logic [IDX_W-1:0]  cand;
  logic              accept;

  // Register array rather than RAM: a swap needs two reads and two
  // writes on the same edge.
  logic [CARD_W-1:0] deck [NUM_CARDS];

  card_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED),
    .TAPS   (TAPS)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Smearing idx's leading one downwards yields (next pow2 >= idx+1) - 1,
  // so cand covers 0..idx with fewer than half of the draws rejected.
  always_comb begin
    mask = idx;
    for (int b = 0; b < IDX_W; b++) begin
      mask = mask | (mask >> 1);
    end
    cand   = lfsr_q[IDX_W-1:0] & mask;
    accept = (cand <= idx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      idx     <= '0;
      for (int s = 0; s < NUM_CARDS; s++) begin
        deck[s] <= '0;
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= FILL;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end

        FILL: begin
          // Slots 2p and 2p+1 both hold card p.
          for (int s = 0; s < NUM_CARDS; s++) begin
            deck[s] <= CARD_W'(s >> 1);
          end
          idx   <= LAST_SLOT;
          state <= SHUFFLE;
        end

        SHUFFLE: begin
          if (accept) begin
            deck[idx]  <= deck[cand];
            deck[cand] <= deck[idx];
            idx        <= idx - 1'b1;
            if (idx == IDX_W'(1)) begin
              state   <= WRITE;
              wr_en   <= 1'b1;
              wr_addr <= '0;
              // The final swap lands on this same edge, so slot 0's
              // post-swap value is picked here directly.
              wr_data <= (cand == '0) ? deck[1] : deck[0];
            end
          end
        end

        WRITE: begin
          if (wr_addr == LAST_SLOT) begin
            state <= DONE;
            wr_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            wr_addr <= wr_addr + 1'b1;
            wr_data <= deck[wr_addr + 1'b1];
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          wr_en <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_lfsr  = lfsr_q;

endmodule
